// File: rtl/day08_pkg.sv
// Shared types and default constants for the day-08 pair sequencer and datapath.
package day08_pkg;

    localparam int COORD_BIT_WIDTH    = 12;
    localparam int DIMENSIONS         = 3;
    localparam int DEF_MAX_NODE_COUNT = 2000;
    localparam int DEF_BATCH_SIZE     = 16;

    typedef logic [COORD_BIT_WIDTH-1:0] coord_t;
    typedef coord_t [DIMENSIONS-1:0]    point_t;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/day08_pair_sequencer_if.sv
// Load path, batch stream and status signals of the pair sequencer.
interface day08_pair_sequencer_if
    import day08_pkg::*;
#(
    parameter int MAX_NODE_COUNT = DEF_MAX_NODE_COUNT,
    parameter int BATCH_SIZE     = DEF_BATCH_SIZE
) ();
    localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);

    logic                                         load_valid;
    logic                                         load_ready;
    point_t                                       load_coords;
    logic                                         load_last;
    point_t [BATCH_SIZE-1:0]                      batch_coords;
    logic   [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0] batch_indices;
    logic   [BATCH_SIZE-1:0]                      batch_valid;
    logic                                         batch_line_end;
    logic                                         batch_stream_end;
    logic                                         in_ready;
    logic                                         busy;
    logic                                         done;
    logic   [INDEX_BIT_WIDTH:0]                   node_count;

    modport master (
        input  load_valid, load_coords, load_last, in_ready,
        output load_ready, batch_coords, batch_indices, batch_valid,
               batch_line_end, batch_stream_end, busy, done, node_count
    );

    modport slave (
        output load_valid, load_coords, load_last, in_ready,
        input  load_ready, batch_coords, batch_indices, batch_valid,
               batch_line_end, batch_stream_end, busy, done, node_count
    );

endinterface

// File: rtl/point_store.sv
// Point register file: one write port, BATCH_SIZE combinational reads at base..base+B-1.
module point_store
    import day08_pkg::*;
#(
    parameter int DEPTH      = DEF_MAX_NODE_COUNT,
    parameter int BATCH_SIZE = DEF_BATCH_SIZE,
    parameter int AW         = $clog2(DEPTH),
    parameter int BW         = AW + 2
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  point_t                  wr_data,
    input  logic [BW-1:0]           rd_base,
    output point_t [BATCH_SIZE-1:0] rd_data
);

    point_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_rd
        logic [BW-1:0] w_addr;
        assign w_addr      = rd_base + BW'(gi);
        assign rd_data[gi] = (w_addr < BW'(DEPTH)) ? r_mem[w_addr[AW-1:0]] : '0;
    end

endmodule

// File: rtl/day08_pair_sequencer.sv
// Loads the point list, then streams every unordered pair once as batched reference lines.
module day08_pair_sequencer
    import day08_pkg::*;
#(
    parameter int MAX_NODE_COUNT = DEF_MAX_NODE_COUNT,
    parameter int BATCH_SIZE     = DEF_BATCH_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    day08_pair_sequencer_if.master bus
);
    localparam int IW = $clog2(MAX_NODE_COUNT);
    localparam int CW = IW + 2;

    seq_state_t r_state, w_state_next;
    logic [IW:0] r_node_count;
    logic [IW:0] r_ref_idx;
    logic [IW:0] r_next_j;
    logic        r_first;

    point_t [BATCH_SIZE-1:0]         r_batch_coords;
    logic   [BATCH_SIZE-1:0][IW-1:0] r_batch_indices;
    logic   [BATCH_SIZE-1:0]         r_batch_valid;
    logic                            r_line_end;
    logic                            r_stream_end;

    logic                            w_load_fire;
    logic                            w_store_full;
    logic                            w_take;
    logic                            w_emit;
    logic   [CW-1:0]                 w_base;
    logic   [CW-1:0]                 w_count;
    logic   [BATCH_SIZE-1:0][CW-1:0] w_slot_idx;
    logic   [BATCH_SIZE-1:0]         w_slot_ok;
    point_t [BATCH_SIZE-1:0]         w_rd_data;
    logic                            w_line_end;
    logic                            w_stream_end;

    assign w_count      = CW'(r_node_count);
    assign w_store_full = (r_node_count == (IW+1)'(MAX_NODE_COUNT));
    assign w_load_fire  = (r_state == ST_LOAD) && bus.load_valid;
    assign w_take       = (|r_batch_valid) && bus.in_ready;
    // Register a new beat when the output is empty (sweep start) or the current one leaves.
    assign w_emit       = (r_state == ST_SWEEP) &&
                          (!(|r_batch_valid) || (w_take && !r_stream_end));

    // A line's first beat starts at the reference itself, so its slots are ref, ref+1, ...
    assign w_base       = r_first ? CW'(r_ref_idx) : CW'(r_next_j);
    assign w_line_end   = (w_base + CW'(BATCH_SIZE)) >= w_count;
    assign w_stream_end = w_line_end && ((CW'(r_ref_idx) + CW'(2)) >= w_count);

    for (genvar gi = 0; gi < BATCH_SIZE; gi++) begin : g_slot
        assign w_slot_idx[gi] = w_base + CW'(gi);
        assign w_slot_ok[gi]  = w_slot_idx[gi] < w_count;
    end

    point_store #(
        .DEPTH      (MAX_NODE_COUNT),
        .BATCH_SIZE (BATCH_SIZE),
        .AW         (IW),
        .BW         (CW)
    ) u_store (
        .clk     (clk),
        .wr_en   (w_load_fire && !w_store_full),
        .wr_addr (r_node_count[IW-1:0]),
        .wr_data (bus.load_coords),
        .rd_base (w_base),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:  if (w_load_fire && (bus.load_last || w_store_full)) w_state_next = ST_SWEEP;
            ST_SWEEP: if (w_take && r_stream_end) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_LOAD;
            default:  w_state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.load_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                bus.load_ready = 1'b1;
                bus.busy       = (r_node_count != '0);
            end
            ST_SWEEP: bus.busy = 1'b1;
            ST_DONE:  bus.done = 1'b1;
            default:  bus.load_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_node_count <= '0;
            r_ref_idx    <= '0;
            r_next_j     <= (IW+1)'(1);
            r_first      <= 1'b1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_ref_idx <= '0;
                    r_next_j  <= (IW+1)'(1);
                    r_first   <= 1'b1;
                    if (w_load_fire && !w_store_full) begin
                        r_node_count <= r_node_count + (IW+1)'(1);
                    end
                end
                ST_SWEEP: begin
                    if (w_emit) begin
                        if (w_line_end) begin
                            r_ref_idx <= r_ref_idx + (IW+1)'(1);
                            r_next_j  <= r_ref_idx + (IW+1)'(2);
                            r_first   <= 1'b1;
                        end else begin
                            r_next_j  <= (IW+1)'(w_base + CW'(BATCH_SIZE));
                            r_first   <= 1'b0;
                        end
                    end
                end
                ST_DONE:  r_node_count <= '0;
                default:  r_node_count <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batch_coords  <= '0;
            r_batch_indices <= '0;
            r_batch_valid   <= '0;
            r_line_end      <= 1'b0;
            r_stream_end    <= 1'b0;
        end else if (w_emit) begin
            for (int k = 0; k < BATCH_SIZE; k++) begin
                r_batch_coords[k]  <= w_slot_ok[k] ? w_rd_data[k] : '0;
                r_batch_indices[k] <= w_slot_ok[k] ? w_slot_idx[k][IW-1:0] : '0;
            end
            r_batch_valid <= w_slot_ok;
            r_line_end    <= w_line_end;
            r_stream_end  <= w_stream_end;
        end else if (w_take) begin
            // Only the stream_end beat is accepted without a successor.
            r_batch_coords  <= '0;
            r_batch_indices <= '0;
            r_batch_valid   <= '0;
            r_line_end      <= 1'b0;
            r_stream_end    <= 1'b0;
        end
    end

    assign bus.batch_coords     = r_batch_coords;
    assign bus.batch_indices    = r_batch_indices;
    assign bus.batch_valid      = r_batch_valid;
    assign bus.batch_line_end   = r_line_end;
    assign bus.batch_stream_end = r_stream_end;
    assign bus.node_count       = r_node_count;

endmodule
